instruction_fetch_unit: RTL and testbench

Sequential fetch stage that consumes the instruction segment base produced by the instruction segment register. It keeps the instruction pointer and forms 20-bit fetch addresses as segment + pointer. It issues one word read at a time to instruction memory over a valid/ready handshake and buffers fetched words with their pointers in a small prefetch queue for decode. A redirect (jump/branch) flushes the queue, reloads the pointer, and discards any in-flight response.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/instruction_fetch_unit_if.sv | 21 ++
 rtl/fetch_queue.sv | 41 ++++
 rtl/instruction_fetch_unit.sv | 76 +++++++
 tb/tb_instruction_fetch_unit.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared address/data widths and the fetch FSM state type
package cpu_pkg;
    localparam int ADDR_WIDTH = 20;
    localparam int DATA_WIDTH = 20;
    typedef enum logic [1:0] {IDLE, REQUEST, WAIT, DISCARD} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction memory and decode handshakes of the fetch stage
interface instruction_fetch_unit_if;
    import cpu_pkg::*;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_address;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0] instr_pointer;
    modport master (
        output mem_req_valid, mem_req_address, instr_valid, instr_data, instr_pointer,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready
    );
    modport slave (
        input  mem_req_valid, mem_req_address, instr_valid, instr_data, instr_pointer,
        output mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous prefetch FIFO with flush; head reads as zero when empty
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    assign head  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: segmented sequential fetch, one outstanding read, prefetch queue
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] instruction_segment,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pointer,
    output logic [ADDR_WIDTH-1:0] instruction_pointer,
    instruction_fetch_unit_if.master bus
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t state, state_next;
    logic accept, pop, push, full, empty, in_flight, slot_after_push;
    logic [CW-1:0] count;
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] head;

    assign accept          = state == REQUEST && bus.mem_req_ready;
    assign in_flight       = state == WAIT || state == DISCARD;
    assign push            = state == WAIT && bus.mem_resp_valid && !redirect_valid;
    assign pop             = bus.instr_valid && bus.instr_ready;
    assign slot_after_push = (count - CW'(pop)) < CW'(QUEUE_DEPTH - 1);

    assign bus.mem_req_valid   = state == REQUEST;
    assign bus.mem_req_address = instruction_segment + instruction_pointer;
    assign bus.instr_valid     = !empty && !redirect_valid;
    assign {bus.instr_data, bus.instr_pointer} = head;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = full ? IDLE : REQUEST;
            REQUEST: state_next = accept ? WAIT : REQUEST;
            WAIT:    state_next = !bus.mem_resp_valid ? WAIT : slot_after_push ? REQUEST : IDLE;
            DISCARD: state_next = bus.mem_resp_valid ? REQUEST : DISCARD;
            default: state_next = IDLE;
        endcase
        // a redirect must still drain a request the memory has taken but not answered
        if (redirect_valid)
            state_next = (accept || (in_flight && !bus.mem_resp_valid)) ? DISCARD : REQUEST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            instruction_pointer <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid)
                instruction_pointer <= redirect_pointer;
            else if (accept)
                instruction_pointer <= instruction_pointer + ADDR_WIDTH'(1);
        end
    end

    // the pointer already advanced at accept, so the word in flight belongs to pointer-1
    fetch_queue #(
        .DEPTH(QUEUE_DEPTH),
        .WIDTH(DATA_WIDTH + ADDR_WIDTH)
    ) u_queue (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(redirect_valid),
        .push_data({bus.mem_resp_data, instruction_pointer - ADDR_WIDTH'(1)}),
        .head(head),
        .count(count),
        .empty(empty),
        .full(full)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized fetch traffic against a queue-level reference model
module tb_instruction_fetch_unit;
    import cpu_pkg::*;
    localparam int QD = 4;

    logic        clk = 0, rst = 1, redirect_valid = 0;
    logic [19:0] instruction_segment = 0, redirect_pointer = 0, instruction_pointer;
    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.QUEUE_DEPTH(QD)) dut (
        .clk(clk),
        .rst(rst),
        .instruction_segment(instruction_segment),
        .redirect_valid(redirect_valid),
        .redirect_pointer(redirect_pointer),
        .instruction_pointer(instruction_pointer),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int ready_pct = 100, irdy_pct = 100, lat_min = 1, lat_max = 1;
    logic rst_req = 1, redir_pend = 0;
    logic [19:0] redir_ptr = 0, seg_v = 0;
    logic mem_pend = 0;
    int mem_lat = 0;
    logic [19:0] mem_addr = 0;
    logic m_known = 0, m_want = 0, m_inflight = 0, m_stale = 0;
    logic [19:0] m_ptr = 0, m_req_ptr = 0;
    logic [39:0] m_q[$];
    logic [19:0] acc_log[$], pop_ptr[$], pop_data[$];
    int first_req, first_iv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic acc, pp, iv_exp;
        int n0;
        logic [19:0] addr_exp;
        @(posedge clk);
        #1;
        rst = rst_req;
        bus.mem_resp_valid = 0;
        if (rst) mem_pend = 0;
        else if (mem_pend) begin
            mem_lat--;
            if (mem_lat == 0) begin
                bus.mem_resp_valid = 1;
                bus.mem_resp_data  = mem_addr ^ 20'hAAAAA;
                mem_pend = 0;
            end
        end
        redirect_valid   = redir_pend;
        redirect_pointer = redir_ptr;
        redir_pend = 0;
        bus.mem_req_ready   = int'($urandom_range(99)) < ready_pct;
        bus.instr_ready     = int'($urandom_range(99)) < irdy_pct;
        instruction_segment = seg_v;
        cyc++;
        @(negedge clk);
        addr_exp = seg_v + m_ptr;
        iv_exp   = m_q.size() > 0 && !redirect_valid;
        if (m_known) begin
            chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(m_want));
            chk("mem_req_address", 32'(bus.mem_req_address), 32'(addr_exp));
            chk("instruction_pointer", 32'(instruction_pointer), 32'(m_ptr));
            chk("instr_valid", 32'(bus.instr_valid), 32'(iv_exp));
            if (iv_exp) begin
                chk("instr_data", 32'(bus.instr_data), 32'(m_q[0][39:20]));
                chk("instr_pointer", 32'(bus.instr_pointer), 32'(m_q[0][19:0]));
            end
        end
        if (bus.instr_valid && bus.instr_ready) begin
            pop_ptr.push_back(bus.instr_pointer);
            pop_data.push_back(bus.instr_data);
        end
        if (bus.mem_req_valid && bus.mem_req_ready) acc_log.push_back(bus.mem_req_address);
        if (rst) begin
            m_q.delete();
            m_ptr = 0; m_want = 0; m_inflight = 0; m_stale = 0; m_known = 1;
        end else begin
            n0  = m_q.size();
            acc = m_want && bus.mem_req_ready;
            pp  = iv_exp && bus.instr_ready;
            if (acc) begin
                mem_pend = 1;
                mem_lat  = $urandom_range(lat_max, lat_min);
                mem_addr = addr_exp;
            end
            if (redirect_valid) begin
                m_q.delete();
                m_ptr      = redirect_pointer;
                m_inflight = acc || (m_inflight && !bus.mem_resp_valid);
                m_stale    = m_inflight;
                m_want     = !m_inflight;
            end else begin
                if (pp) void'(m_q.pop_front());
                if (acc) begin
                    m_req_ptr = m_ptr;
                    m_ptr++;
                    m_want = 0; m_inflight = 1; m_stale = 0;
                end else if (m_inflight && bus.mem_resp_valid) begin
                    if (!m_stale) m_q.push_back({bus.mem_resp_data, m_req_ptr});
                    m_want = m_stale || m_q.size() < QD;
                    m_inflight = 0; m_stale = 0;
                end else if (!m_want && !m_inflight) begin
                    m_want = n0 < QD;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_req = 1;
        step();
        step();
        rst_req = 0;
        acc_log.delete(); pop_ptr.delete(); pop_data.delete();
        cyc = 0;
    endtask

    initial begin
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = 0; bus.instr_ready = 0;
        seg_v = 20'h01000;
        rst_req = 1;
        repeat (3) step();
        chk("reset_req_valid", 32'(bus.mem_req_valid), 0);
        chk("reset_instr_valid", 32'(bus.instr_valid), 0);
        chk("reset_ip", 32'(instruction_pointer), 0);
        chk("reset_address", 32'(bus.mem_req_address), 32'h01000);
        chk("reset_instr_data", 32'(bus.instr_data), 0);
        chk("reset_instr_pointer", 32'(bus.instr_pointer), 0);

        // stream with an always-ready, single-cycle memory
        do_reset();
        first_req = 0; first_iv = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (first_req == 0 && bus.mem_req_valid) first_req = cyc;
            if (first_iv == 0 && bus.instr_valid) first_iv = cyc;
        end
        chk("stream_first_req", 32'(first_req), 2);
        chk("stream_first_iv", 32'(first_iv), 4);
        chk("stream_pop_count", 32'(pop_ptr.size()), 5);
        if (pop_ptr.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("stream_ptr", 32'(pop_ptr[i]), 32'(i));
            chk("stream_data0", 32'(pop_data[0]), 32'hABAAA);
            chk("stream_data1", 32'(pop_data[1]), 32'hABAAB);
            chk("stream_data2", 32'(pop_data[2]), 32'hABAA8);
            chk("stream_data3", 32'(pop_data[3]), 32'hABAA9);
        end

        // backpressure fills the queue, then fetch resumes at pointer 4
        do_reset();
        irdy_pct = 0;
        repeat (20) step();
        chk("bp_requests", 32'(acc_log.size()), 4);
        chk("bp_req_valid", 32'(bus.mem_req_valid), 0);
        chk("bp_ip", 32'(instruction_pointer), 4);
        irdy_pct = 100;
        acc_log.delete();
        for (int i = 0; i < 20 && acc_log.size() == 0; i++) step();
        chk("bp_resume_seen", 32'(acc_log.size() > 0), 1);
        if (acc_log.size() > 0) chk("bp_resume_addr", 32'(acc_log[0]), 32'h01004);

        // pointer wrap with carry dropped from the address
        do_reset();
        seg_v = 20'h00002;
        redir_ptr = 20'hFFFFF; redir_pend = 1;
        repeat (12) step();
        if (acc_log.size() >= 2 && pop_ptr.size() >= 2) begin
            chk("wrap_addr0", 32'(acc_log[0]), 32'h00001);
            chk("wrap_addr1", 32'(acc_log[1]), 32'h00002);
            chk("wrap_ptr0", 32'(pop_ptr[0]), 32'hFFFFF);
            chk("wrap_ptr1", 32'(pop_ptr[1]), 32'h00000);
        end else chk("wrap_activity", 0, 1);

        // redirect while waiting on a 3-cycle response
        seg_v = 20'h01000; lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 20 && acc_log.size() == 0; i++) step();
        redir_ptr = 20'h00100; redir_pend = 1;
        acc_log.delete(); pop_ptr.delete(); pop_data.delete();
        step();
        chk("rw_iv_redirect", 32'(bus.instr_valid), 0);
        step();
        chk("rw_discard_req", 32'(bus.mem_req_valid), 0);
        chk("rw_queue_empty", 32'(bus.instr_valid), 0);
        repeat (20) step();
        if (acc_log.size() > 0 && pop_ptr.size() > 0) begin
            chk("rw_next_addr", 32'(acc_log[0]), 32'h01100);
            chk("rw_first_ptr", 32'(pop_ptr[0]), 32'h00100);
            chk("rw_first_data", 32'(pop_data[0]), 32'hABBAA);
        end else chk("rw_activity", 0, 1);

        // redirect coinciding with request accept and a head pop
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (3) step();
        redir_ptr = 20'h00200; redir_pend = 1;
        step();
        chk("ra_iv_gated", 32'(bus.instr_valid), 0);
        chk("ra_req_valid", 32'(bus.mem_req_valid), 1);
        chk("ra_no_pop", 32'(pop_ptr.size()), 0);
        step();
        chk("ra_discard_req", 32'(bus.mem_req_valid), 0);
        repeat (10) step();
        if (pop_ptr.size() > 0) begin
            chk("ra_first_ptr", 32'(pop_ptr[0]), 32'h00200);
            chk("ra_first_data", 32'(pop_data[0]), 32'hAB8AA);
        end else chk("ra_activity", 0, 1);

        // memory stall, then reset mid-stall
        ready_pct = 0;
        do_reset();
        redir_ptr = 20'h00050; redir_pend = 1;
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_req_valid", 32'(bus.mem_req_valid), 1);
            chk("stall_addr", 32'(bus.mem_req_address), 32'h01050);
            chk("stall_ip", 32'(instruction_pointer), 32'h00050);
        end
        rst_req = 1;
        step();
        step();
        chk("stall_rst_req", 32'(bus.mem_req_valid), 0);
        chk("stall_rst_iv", 32'(bus.instr_valid), 0);
        chk("stall_rst_ip", 32'(instruction_pointer), 0);
        chk("stall_rst_addr", 32'(bus.mem_req_address), 32'h01000);
        rst_req = 0;

        // randomized traffic checked cycle by cycle against the model
        ready_pct = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            irdy_pct = (i < 1000) ? 60 : (i < 2000) ? 15 : 95;
            redir_pend = int'($urandom_range(99)) < 4;
            redir_ptr  = 20'($urandom);
            if ($urandom_range(49) == 0) seg_v = 20'($urandom);
            rst_req = $urandom_range(999) < 5;
            step();
        end
        rst_req = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
